// File: rtl/cnn_fixed_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_fixed_pkg
// Description : Shared Q8.8 fixed-point widths, round/saturate helpers and
//               the sequential-layer FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_fixed_pkg;

    localparam int c_DATA_WIDTH = 16;
    localparam int c_FRAC       = 8;
    localparam int c_ACC_WIDTH  = 40;

    localparam int         c_STATE_W  = 3;
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LOAD  = 3'd1;
    localparam logic [2:0] c_ST_MAC   = 3'd2;
    localparam logic [2:0] c_ST_WRITE = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    // Round half up, then arithmetic shift out the fractional bits.
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] val,
                                                       input int frac);
        return (val + (64'sd1 <<< (frac - 1))) >>> frac;
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] val,
                                                    input int dw);
        logic signed [63:0] v_max;
        logic signed [63:0] v_min;
        v_max = (64'sd1 <<< (dw - 1)) - 64'sd1;
        v_min = -(64'sd1 <<< (dw - 1));
        if (val > v_max) return v_max;
        if (val < v_min) return v_min;
        return val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fc_mac_unit.sv
`default_nettype none
// ============================================================================
// Module      : fc_mac_unit
// Description : Signed MAC with clear, plus round/bias/saturate score path.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_mac_unit
    import cnn_fixed_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int FRAC       = c_FRAC,
    parameter int ACC_WIDTH  = c_ACC_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clr,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    input  logic signed [DATA_WIDTH-1:0] bias,
    output logic signed [ACC_WIDTH-1:0]  acc_out,
    output logic signed [DATA_WIDTH-1:0] score
);

    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]    r_acc;
    logic signed [63:0]             w_acc64;
    logic signed [63:0]             w_bias64;
    logic signed [63:0]             w_sum;

    assign w_prod = a * b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= r_acc + {{(ACC_WIDTH-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};
        end
    end

    assign w_acc64  = {{(64-ACC_WIDTH){r_acc[ACC_WIDTH-1]}}, r_acc};
    assign w_bias64 = {{(64-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
    assign w_sum    = round_shift(w_acc64, FRAC) + w_bias64;
    assign score    = DATA_WIDTH'(saturate(w_sum, DATA_WIDTH));
    assign acc_out  = r_acc;

endmodule
`default_nettype wire

// File: rtl/fc_layer_seq.sv
`default_nettype none
// ============================================================================
// Module      : fc_layer_seq
// Description : Sequential fully-connected layer, one shared MAC, with argmax.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_layer_seq
    import cnn_fixed_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int FRAC       = c_FRAC,
    parameter int IN_NODES   = 288,
    parameter int OUT_NODES  = 10,
    parameter int ACC_WIDTH  = c_ACC_WIDTH,
    parameter int IDX_WIDTH  = $clog2(OUT_NODES)
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    start,
    input  logic [IN_NODES*DATA_WIDTH-1:0]           features,
    input  logic [OUT_NODES*IN_NODES*DATA_WIDTH-1:0] weights,
    input  logic [OUT_NODES*DATA_WIDTH-1:0]          biases,
    output logic                                    busy,
    output logic                                    done,
    output logic [OUT_NODES*DATA_WIDTH-1:0]          output_fc,
    output logic [IDX_WIDTH-1:0]                    class_idx
);

    localparam int                   c_I_W    = (IN_NODES > 1) ? $clog2(IN_NODES) : 1;
    localparam logic [c_I_W-1:0]     c_I_LAST = c_I_W'(IN_NODES - 1);
    localparam logic [IDX_WIDTH-1:0] c_J_LAST = IDX_WIDTH'(OUT_NODES - 1);

    logic [c_STATE_W-1:0]          r_state;
    logic [c_I_W-1:0]              r_i;
    logic [IDX_WIDTH-1:0]          r_j;
    logic signed [DATA_WIDTH-1:0]  r_best;
    logic signed [DATA_WIDTH-1:0]  r_out  [OUT_NODES];
    logic signed [DATA_WIDTH-1:0]  r_feat [IN_NODES];
    logic signed [DATA_WIDTH-1:0]  r_wgt  [OUT_NODES][IN_NODES];
    logic signed [DATA_WIDTH-1:0]  r_bias [OUT_NODES];

    logic                          w_clr;
    logic                          w_en;
    logic signed [ACC_WIDTH-1:0]   w_acc;
    logic signed [DATA_WIDTH-1:0]  w_score;

    // Operand snapshot; inputs are free to change once LOAD has passed.
    always_ff @(posedge clk) begin
        if (r_state == c_ST_LOAD) begin
            for (int k = 0; k < IN_NODES; k++) begin
                r_feat[k] <= features[k*DATA_WIDTH +: DATA_WIDTH];
            end
            for (int m = 0; m < OUT_NODES; m++) begin
                r_bias[m] <= biases[m*DATA_WIDTH +: DATA_WIDTH];
                for (int k = 0; k < IN_NODES; k++) begin
                    r_wgt[m][k] <= weights[(m*IN_NODES+k)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign w_clr = (r_state == c_ST_LOAD) || (r_state == c_ST_WRITE);
    assign w_en  = (r_state == c_ST_MAC);

    fc_mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC       (FRAC),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (w_clr),
        .en      (w_en),
        .a       (r_feat[r_i]),
        .b       (r_wgt[r_j][r_i]),
        .bias    (r_bias[r_j]),
        .acc_out (w_acc),
        .score   (w_score)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            r_i       <= '0;
            r_j       <= '0;
            r_best    <= '0;
            class_idx <= '0;
            for (int k = 0; k < OUT_NODES; k++) r_out[k] <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state <= c_ST_LOAD;
                        busy    <= 1'b1;
                    end
                end
                c_ST_LOAD: begin
                    r_i       <= '0;
                    r_j       <= '0;
                    r_best    <= '0;
                    class_idx <= '0;
                    for (int k = 0; k < OUT_NODES; k++) r_out[k] <= '0;
                    r_state   <= c_ST_MAC;
                end
                c_ST_MAC: begin
                    if (r_i == c_I_LAST) begin
                        r_i     <= '0;
                        r_state <= c_ST_WRITE;
                    end else begin
                        r_i <= r_i + 1'b1;
                    end
                end
                c_ST_WRITE: begin
                    r_out[r_j] <= w_score;
                    // Strict compare keeps the lower index on ties.
                    if ((r_j == '0) || (w_score > r_best)) begin
                        r_best    <= w_score;
                        class_idx <= r_j;
                    end
                    if (r_j == c_J_LAST) begin
                        r_state <= c_ST_DONE;
                        done    <= 1'b1;
                    end else begin
                        r_j     <= r_j + 1'b1;
                        r_state <= c_ST_MAC;
                    end
                end
                c_ST_DONE: begin
                    busy    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Every dot product must begin from a cleared accumulator.
    always_ff @(posedge clk) begin
        if (reset_n && (r_state == c_ST_MAC) && (r_i == '0)) begin
            assert (w_acc == '0);
        end
    end

    for (genvar g = 0; g < OUT_NODES; g++) begin : g_out
        assign output_fc[g*DATA_WIDTH +: DATA_WIDTH] = r_out[g];
    end

endmodule
`default_nettype wire
